// File: rtl/cfg_chain_master.sv
// cfg_chain_master: serial write / parallel-capture readback master for a shift-register config chain.
// Readback hardware exists only when CFG_CHAIN_MASTER_READBACK_EN is defined.
module cfg_chain_master #(
  parameter int unsigned N = 100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] rd_data,
  output logic         ch_s_in,
  output logic         ch_load,
  output logic         ch_read,
  input  logic         ch_s_out
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    LOAD    = 3'd2,
    READ    = 3'd3,
    RDSHIFT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [N-1:0]  shadow;

  assign cnt_inc = cnt + CW'(1);

  // Outputs are computed one cycle ahead so every chain-facing strobe comes from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      shadow  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ch_s_in <= 1'b0;
      ch_load <= 1'b0;
`ifdef CFG_CHAIN_MASTER_READBACK_EN
      ch_read <= 1'b0;
      rd_data <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt  <= '0;
            busy <= 1'b1;
`ifdef CFG_CHAIN_MASTER_READBACK_EN
            if (op) begin
              state   <= READ;
              ch_read <= 1'b1;
            end else begin
              shadow  <= wr_data;
              state   <= SHIFT;
              ch_s_in <= wr_data[0];
            end
`else
            shadow  <= wr_data;
            state   <= SHIFT;
            ch_s_in <= wr_data[0];
`endif
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            state   <= LOAD;
            ch_s_in <= 1'b0;
            ch_load <= 1'b1;
          end else begin
            cnt     <= cnt_inc;
            ch_s_in <= shadow[cnt_inc];
          end
        end
        LOAD: begin
          state   <= DONE;
          ch_load <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
`ifdef CFG_CHAIN_MASTER_READBACK_EN
        READ: begin
          state   <= RDSHIFT;
          ch_read <= 1'b0;
          cnt     <= '0;
        end
        RDSHIFT: begin
          rd_data[cnt] <= ch_s_out;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          ch_s_in <= 1'b0;
          ch_load <= 1'b0;
`ifdef CFG_CHAIN_MASTER_READBACK_EN
          ch_read <= 1'b0;
`endif
        end
      endcase
    end
  end

`ifndef CFG_CHAIN_MASTER_READBACK_EN
  // Without readback, op is a don't-care and the chain's serial output goes nowhere.
  logic unused_inputs;
  assign unused_inputs = op ^ ch_s_out;
  assign rd_data       = '0;
  assign ch_read       = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_master.sv
// tb_cfg_chain_master: N=8 bench with a behavioural config chain; expectations come from the op timing rules.
`timescale 1ns/1ps
module tb_cfg_chain_master;

  localparam int unsigned N = 8;
`ifdef CFG_CHAIN_MASTER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [N-1:0] wr_data;
  logic         busy;
  logic         done;
  logic [N-1:0] rd_data;
  logic         ch_s_in;
  logic         ch_load;
  logic         ch_read;
  logic         ch_s_out;

  int checks   = 0;
  int failures = 0;

  // Chain: shift right (s_in at MSB), latch on load, parallel capture on read.
  logic [N-1:0] sr         = '0;
  logic [N-1:0] latched    = '0;
  logic [N-1:0] par_in     = '0;
  int           load_count = 0;
  int           read_count = 0;

  // Reference-model state
  logic [N-1:0] last_latched = '0;
  logic [N-1:0] last_rd      = '0;
  int           exp_reads    = 0;

  cfg_chain_master #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .rd_data (rd_data),
    .ch_s_in (ch_s_in),
    .ch_load (ch_load),
    .ch_read (ch_read),
    .ch_s_out(ch_s_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ch_load) begin
      latched    <= sr;
      load_count <= load_count + 1;
    end else if (ch_read) begin
      sr         <= par_in;
      read_count <= read_count + 1;
    end else begin
      sr <= {ch_s_in, sr[N-1:1]};
    end
  end
  assign ch_s_out = sr[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One operation from an IDLE negedge; per-cycle {busy,done,s_in,load,read} derived from the timing rules.
  task automatic run_op(input logic op_i, input logic [N-1:0] wd, input logic [N-1:0] pin);
    logic       rd_eff;
    logic [4:0] exp_v;
    rd_eff  = op_i & RB;
    par_in  = pin;
    start   = 1'b1;
    op      = op_i;
    wr_data = wd;
    @(posedge clk);
    #1;
    start   = 1'b0;
    op      = 1'b0;
    wr_data = N'($urandom);
    for (int c = 1; c <= N + 2; c++) begin
      @(negedge clk);
      if (c == N + 2)      exp_v = 5'b01000;
      else if (rd_eff)     exp_v = {4'b1000, (c == 1)};
      else if (c == N + 1) exp_v = 5'b10010;
      else                 exp_v = {2'b10, wd[c-1], 2'b00};
      check($sformatf("trace op=%0d cyc%0d", op_i, c), 32'({busy, done, ch_s_in, ch_load, ch_read}), 32'(exp_v));
      if (!rd_eff) check("rd_data hold", 32'(rd_data), 32'(last_rd));
    end
    if (rd_eff) begin
      last_rd = pin;
      exp_reads++;
    end else begin
      last_latched = wd;
    end
    check("rd_data at done", 32'(rd_data), 32'(last_rd));
    check("latched after op", 32'(latched), 32'(last_latched));
    @(negedge clk);
    check("idle after done", 32'({busy, done}), 32'(0));
  endtask

  typedef struct {
    logic         op;
    logic [N-1:0] wd;
    logic [N-1:0] pin;
    logic [N-1:0] exp_latched;
    logic [N-1:0] exp_rd;
  } vec_t;

  vec_t vecs[6];
  int   lc0;

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 8'h00, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 8'h5A, 8'h3C, RB ? 8'hA5 : 8'h5A, RB ? 8'h3C : 8'h00};
    vecs[2] = '{1'b0, 8'h00, 8'hFF, 8'h00, RB ? 8'h3C : 8'h00};
    vecs[3] = '{1'b0, 8'hFF, 8'h00, 8'hFF, RB ? 8'h3C : 8'h00};
    vecs[4] = '{1'b1, 8'hC3, 8'h81, RB ? 8'hFF : 8'hC3, RB ? 8'h81 : 8'h00};
    vecs[5] = '{1'b0, 8'h01, 8'h7E, 8'h01, RB ? 8'h81 : 8'h00};

    reset   = 1'b1;
    start   = 1'b0;
    op      = 1'b0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    check("reset outputs", 32'({busy, done, ch_s_in, ch_load, ch_read, rd_data}), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // Reset in SHIFT cycle 4 of an 8'h0F write: everything drops at once, no latch.
    start = 1'b1; op = 1'b0; wr_data = 8'h0F;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'(1));
    reset = 1'b1;
    #1;
    check("async reset outputs", 32'({busy, done, ch_s_in, ch_load, ch_read, rd_data}), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (N + 4) @(negedge clk);
    check("no load after reset", 32'(load_count), 32'(0));
    check("latched unchanged", 32'(latched), 32'(8'h00));
    check("idle after reset", 32'(busy), 32'(0));

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].op, vecs[i].wd, vecs[i].pin);
      check($sformatf("vec%0d latched", i), 32'(latched), 32'(vecs[i].exp_latched));
      check($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
    end

    // Start pulse with 8'hFF during SHIFT cycle 3 must be ignored.
    lc0 = load_count;
    start = 1'b1; op = 1'b0; wr_data = 8'h66;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= N + 2; c++) begin
      @(negedge clk);
      if (c == 3) begin start = 1'b1; wr_data = 8'hFF; end
      if (c == 4) start = 1'b0;
    end
    check("busy-start done", 32'(done), 32'(1));
    repeat (N + 4) @(negedge clk);
    check("busy-start one load", 32'(load_count - lc0), 32'(1));
    check("busy-start latched", 32'(latched), 32'(8'h66));
    check("busy-start no 2nd op", 32'(busy), 32'(0));
    last_latched = 8'h66;

    // Back-to-back with start held: second write accepted in the IDLE cycle after DONE.
    start = 1'b1; op = 1'b0; wr_data = 8'h01;
    @(posedge clk); #1; wr_data = 8'h80;
    for (int c = 1; c <= 2 * N + 5; c++) begin
      @(negedge clk);
      if (c == N + 2) begin
        check("b2b first done", 32'(done), 32'(1));
        check("b2b first latched", 32'(latched), 32'(8'h01));
      end
      if (c == N + 3) check("b2b idle gap", 32'({busy, done}), 32'(0));
      if (c == N + 4) begin
        check("b2b second accepted", 32'({busy, ch_s_in}), 32'(2'b10));
        start = 1'b0;
      end
      if (c == 2 * N + 5) begin
        check("b2b second done", 32'(done), 32'(1));
        check("b2b second latched", 32'(latched), 32'(8'h80));
      end
    end
    last_latched = 8'h80;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      run_op(1'($urandom_range(0, 1)), N'($urandom), N'($urandom));
    end

    check("ch_read pulse count", 32'(read_count), 32'(exp_reads));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
